// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester and memory-controller signals of mem_arbiter.
// slave  : arbiter view (takes requests, issues controller transfers).
// master : environment view (requesters plus memory controller).
// Handshake: a requester raises req_valid[i] with its fields stable and holds
// them until it sees the one-cycle req_ready[i] completion pulse; the arbiter
// holds mc_valid with stable mc_* fields until a cycle with mc_ready high.
interface mem_arbiter_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [NUM_CH-1:0]        req_valid;
    logic [NUM_CH-1:0]        req_wr;
    logic [3*NUM_CH-1:0]      req_size;
    logic [ADDR_W*NUM_CH-1:0] req_addr;
    logic [DATA_W*NUM_CH-1:0] req_wdata;
    logic [NUM_CH-1:0]        req_ready;
    logic [DATA_W-1:0]        resp_data;
    logic                     mc_valid;
    logic                     mc_wr;
    logic [ADDR_W-1:0]        mc_addr;
    logic [2:0]               mc_len;
    logic [DATA_W-1:0]        mc_data;
    logic                     mc_ready;
    logic [DATA_W-1:0]        mc_res;
    logic                     mc_abort;

    modport slave (
        input  req_valid, req_wr, req_size, req_addr, req_wdata, mc_ready, mc_res,
        output req_ready, resp_data, mc_valid, mc_wr, mc_addr, mc_len, mc_data, mc_abort
    );

    modport master (
        output req_valid, req_wr, req_size, req_addr, req_wdata, mc_ready, mc_res,
        input  req_ready, resp_data, mc_valid, mc_wr, mc_addr, mc_len, mc_data, mc_abort
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates NUM_CH requesters onto one memory-controller port.
// Two-state FSM (IDLE/BUSY). A grant latches the winner into registered mc_*
// outputs; completion is reported combinationally on req_ready/resp_data in
// the cycle mc_ready is seen. clear_in aborts reads but never writes.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration;
// without it, fixed priority with channel 0 highest.
module mem_arbiter #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic           rdy_in,
    input  logic           clear_in,
    mem_arbiter_if.slave   bus,
    output logic [0:0]     dbg_state_o
);
    localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic              mc_valid_q, mc_valid_d;
    logic              mc_wr_q, mc_wr_d;
    logic [ADDR_W-1:0] mc_addr_q, mc_addr_d;
    logic [2:0]        mc_len_q, mc_len_d;
    logic [DATA_W-1:0] mc_data_q, mc_data_d;
    logic              mc_abort_q, mc_abort_d;
    // Low for exactly one edge after reset release so no grant can happen on it.
    logic              armed_q;

    logic [GW-1:0]     scan_base;
    logic              win_found;
    logic [GW-1:0]     win_idx;
    logic              win_wr;
    logic [2:0]        win_len;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;

    logic              busy_go;
    logic              launch;
    logic              abort;
    logic              complete;
    logic [NUM_CH-1:0] req_ready;

`ifdef ARB_ROUND_ROBIN_EN
    logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]     grant_wrap;

    // Channel after the current grant, wrapping past NUM_CH-1 to 0.
    always_comb begin
        grant_wrap = grant_q + GW'(1);
        if (grant_q == GW'(NUM_CH - 1)) begin
            grant_wrap = '0;
        end
    end

    // Pointer advances on every finished transfer, aborted or completed.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (complete || abort) begin
            rr_ptr_d = grant_wrap;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign scan_base = rr_ptr_q;
`else
    assign scan_base = '0;
`endif

    // Winner search: first valid channel at or after scan_base, wrapping.
    always_comb begin
        int j;
        win_found = 1'b0;
        win_idx   = '0;
        win_wr    = 1'b0;
        win_len   = '0;
        win_addr  = '0;
        win_data  = '0;
        j         = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            j = int'(scan_base) + i;
            if (j >= NUM_CH) begin
                j = j - NUM_CH;
            end
            if (!win_found && bus.req_valid[j]) begin
                win_found = 1'b1;
                win_idx   = GW'(j);
                win_wr    = bus.req_wr[j];
                win_len   = bus.req_size[3*j +: 3];
                win_addr  = bus.req_addr[ADDR_W*j +: ADDR_W];
                win_data  = bus.req_wdata[DATA_W*j +: DATA_W];
            end
        end
    end

    // Event decode; everything is gated by rdy_in so a stall freezes the FSM.
    // A write in flight ignores clear_in so committed stores always finish.
    always_comb begin
        busy_go  = rdy_in && (state_q == ST_BUSY);
        abort    = busy_go && clear_in && !mc_wr_q;
        complete = busy_go && bus.mc_ready && !abort;
        launch   = rdy_in && armed_q && !clear_in && (state_q == ST_IDLE) && win_found;
    end

    // Next-state and controller-request register updates.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        mc_valid_d = mc_valid_q;
        mc_wr_d    = mc_wr_q;
        mc_addr_d  = mc_addr_q;
        mc_len_d   = mc_len_q;
        mc_data_d  = mc_data_q;
        mc_abort_d = 1'b0;
        if (launch) begin
            state_d    = ST_BUSY;
            grant_d    = win_idx;
            mc_valid_d = 1'b1;
            mc_wr_d    = win_wr;
            mc_addr_d  = win_addr;
            mc_len_d   = win_len;
            mc_data_d  = win_data;
        end else if (abort) begin
            state_d    = ST_IDLE;
            mc_valid_d = 1'b0;
            mc_abort_d = 1'b1;
        end else if (complete) begin
            state_d    = ST_IDLE;
            mc_valid_d = 1'b0;
        end
    end

    // State registers; mc_abort is a single-cycle pulse even across stalls.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            mc_valid_q <= 1'b0;
            mc_wr_q    <= 1'b0;
            mc_addr_q  <= '0;
            mc_len_q   <= '0;
            mc_data_q  <= '0;
            mc_abort_q <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            mc_valid_q <= mc_valid_d;
            mc_wr_q    <= mc_wr_d;
            mc_addr_q  <= mc_addr_d;
            mc_len_q   <= mc_len_d;
            mc_data_q  <= mc_data_d;
            mc_abort_q <= mc_abort_d;
            armed_q    <= 1'b1;
        end
    end

    // One-hot completion pulse toward the granted requester.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            req_ready[i] = complete && (grant_q == GW'(i));
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.resp_data = bus.mc_res;
    assign bus.mc_valid  = mc_valid_q;
    assign bus.mc_wr     = mc_wr_q;
    assign bus.mc_addr   = mc_addr_q;
    assign bus.mc_len    = mc_len_q;
    assign bus.mc_data   = mc_data_q;
    assign bus.mc_abort  = mc_abort_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed test of mem_arbiter (NUM_CH=2). Single-channel
// transactions come from a vector table; contention, clear, stall and reset
// corner cases are hand-written sequences. Expectations follow the build's
// arbitration policy (ARB_ROUND_ROBIN_EN).
module tb_mem_arbiter;
    localparam int NUM_CH = 2;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       rdy;
    logic       clear;
    logic [0:0] dbg_state;

    int n_pass  = 0;
    int n_total = 0;

    mem_arbiter_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_in      (clk),
        .rst_in      (rst),
        .rdy_in      (rdy),
        .clear_in    (clear),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          ch;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] res;
        logic [1:0]  exp_rdy;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid = '0;
        bus.req_wr    = '0;
        bus.req_size  = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.mc_ready  = 1'b0;
        bus.mc_res    = '0;
        clear         = 1'b0;
        rdy           = 1'b1;
    endtask

    task automatic set_ch(input int ch, input logic wr, input logic [2:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_wr[ch]                  = wr;
        bus.req_size[3*ch +: 3]         = size;
        bus.req_addr[ADDR_W*ch +: ADDR_W] = addr;
        bus.req_wdata[DATA_W*ch +: DATA_W] = wdata;
    endtask

    // Reset pulse; returns after the edge on which no grant may occur.
    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // One complete transaction on a single channel, other channel loaded with
    // decoy fields so a wrong-channel latch shows up.
    task automatic run_vec(input vec_t v);
        for (int c = 0; c < NUM_CH; c++) begin
            set_ch(c, ~v.wr, ~v.size, ~v.addr, ~v.wdata);
        end
        set_ch(v.ch, v.wr, v.size, v.addr, v.wdata);
        bus.req_valid       = '0;
        bus.req_valid[v.ch] = 1'b1;
        #1;
        chk({v.name, ".pre_mc_valid"}, bus.mc_valid, 1'b0);
        step();
        chk({v.name, ".mc_valid"}, bus.mc_valid, 1'b1);
        chk({v.name, ".mc_wr"}, bus.mc_wr, v.wr);
        chk({v.name, ".mc_addr"}, bus.mc_addr, v.addr);
        chk({v.name, ".mc_len"}, bus.mc_len, v.size);
        chk({v.name, ".mc_data"}, bus.mc_data, v.wdata);
        chk({v.name, ".state_busy"}, dbg_state, 1'b1);
        for (int i = 1; i < v.lat; i++) begin
            chk({v.name, ".wait_req_ready"}, bus.req_ready, 2'b00);
            step();
        end
        bus.mc_ready = 1'b1;
        bus.mc_res   = v.res;
        #1;
        chk({v.name, ".req_ready"}, bus.req_ready, v.exp_rdy);
        chk({v.name, ".resp_data"}, bus.resp_data, v.res);
        step();
        bus.req_valid = '0;
        bus.mc_ready  = 1'b0;
        chk({v.name, ".done_mc_valid"}, bus.mc_valid, 1'b0);
        chk({v.name, ".done_state"}, dbg_state, 1'b0);
        chk({v.name, ".done_req_ready"}, bus.req_ready, 2'b00);
    endtask

    logic [1:0]  exp_g[4];
    logic [31:0] exp_a;
    int          waited;

    initial begin
        vecs[0] = '{"single_read_ch1", 1, 1'b0, 3'd2, 32'h0000_1000, 32'h0,         4, 32'hDEAD_BEEF, 2'b10};
        vecs[1] = '{"read_ch0_lat1",   0, 1'b0, 3'd3, 32'h0000_0040, 32'h0,         1, 32'h1234_5678, 2'b01};
        vecs[2] = '{"write_ch0",       0, 1'b1, 3'd2, 32'h0002_0000, 32'h0000_0055, 2, 32'h0,         2'b01};
        vecs[3] = '{"write_ch1_top",   1, 1'b1, 3'd7, 32'hFFFF_FFFC, 32'hA5A5_5A5A, 3, 32'hCAFE_F00D, 2'b10};
        vecs[4] = '{"read_ch1_size5",  1, 1'b0, 3'd5, 32'h8000_0001, 32'h0,         1, 32'h0BAD_F00D, 2'b10};
`ifdef ARB_ROUND_ROBIN_EN
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif

        // Reset values
        idle_inputs();
        bus.mc_res = 32'h1357_2468;
        rst = 1'b1;
        step();
        step();
        chk("rst.state", dbg_state, 1'b0);
        chk("rst.mc_valid", bus.mc_valid, 1'b0);
        chk("rst.mc_wr", bus.mc_wr, 1'b0);
        chk("rst.mc_addr", bus.mc_addr, 32'h0);
        chk("rst.mc_len", bus.mc_len, 3'd0);
        chk("rst.mc_data", bus.mc_data, 32'h0);
        chk("rst.mc_abort", bus.mc_abort, 1'b0);
        chk("rst.req_ready", bus.req_ready, 2'b00);
        chk("rst.resp_data", bus.resp_data, 32'h1357_2468);
        rst = 1'b0;
        step();

        // Table-driven single transactions
        for (int k = 0; k < 5; k++) begin
            run_vec(vecs[k]);
        end

        // Contention: both channels valid the whole time
        do_reset();
        set_ch(0, 1'b0, 3'd2, 32'h0000_0100, 32'h0);
        set_ch(1, 1'b0, 3'd2, 32'h0000_0200, 32'h0);
        bus.req_valid = 2'b11;
        for (int g = 0; g < 4; g++) begin
            waited = 0;
            while (bus.mc_valid !== 1'b1 && waited < 8) begin
                step();
                waited++;
            end
            chk("contend.grant_in_time", (waited < 8), 1'b1);
            exp_a = (exp_g[g] == 2'b01) ? 32'h0000_0100 : 32'h0000_0200;
            chk("contend.mc_addr", bus.mc_addr, exp_a);
            bus.mc_ready = 1'b1;
            bus.mc_res   = 32'h1000 + g;
            #1;
            chk("contend.req_ready", bus.req_ready, exp_g[g]);
            step();
            bus.mc_ready = 1'b0;
            chk("contend.idle_gap", bus.mc_valid, 1'b0);
        end
        bus.req_valid = '0;
        step();

        // clear_in while IDLE blocks the grant for that cycle
        set_ch(0, 1'b0, 3'd1, 32'h0000_0300, 32'h0);
        bus.req_valid = 2'b01;
        clear = 1'b1;
        step();
        chk("clr_idle.mc_valid", bus.mc_valid, 1'b0);
        chk("clr_idle.state", dbg_state, 1'b0);
        clear = 1'b0;
        step();
        chk("clr_idle.late_grant", bus.mc_valid, 1'b1);
        bus.mc_ready = 1'b1;
        #1;
        chk("clr_idle.req_ready", bus.req_ready, 2'b01);
        step();
        bus.mc_ready  = 1'b0;
        bus.req_valid = '0;

        // clear_in on a read with mc_ready in the same cycle aborts it
        set_ch(1, 1'b0, 3'd2, 32'h0000_0400, 32'h0);
        bus.req_valid = 2'b10;
        step();
        chk("clr_rd.mc_valid", bus.mc_valid, 1'b1);
        step();
        clear        = 1'b1;
        bus.mc_ready = 1'b1;
        bus.mc_res   = 32'h77;
        #1;
        chk("clr_rd.req_ready", bus.req_ready, 2'b00);
        chk("clr_rd.abort_not_yet", bus.mc_abort, 1'b0);
        step();
        clear         = 1'b0;
        bus.mc_ready  = 1'b0;
        bus.req_valid = '0;
        chk("clr_rd.mc_abort", bus.mc_abort, 1'b1);
        chk("clr_rd.mc_valid_low", bus.mc_valid, 1'b0);
        chk("clr_rd.state", dbg_state, 1'b0);
        step();
        chk("clr_rd.abort_pulse_end", bus.mc_abort, 1'b0);

        // clear_in on a write lets it finish
        set_ch(0, 1'b1, 3'd2, 32'h0002_0000, 32'h0000_0055);
        bus.req_valid = 2'b01;
        step();
        chk("clr_wr.mc_wr", bus.mc_wr, 1'b1);
        chk("clr_wr.mc_data", bus.mc_data, 32'h55);
        clear = 1'b1;
        step();
        chk("clr_wr.no_abort", bus.mc_abort, 1'b0);
        chk("clr_wr.still_busy", dbg_state, 1'b1);
        chk("clr_wr.mc_valid", bus.mc_valid, 1'b1);
        bus.mc_ready = 1'b1;
        #1;
        chk("clr_wr.req_ready", bus.req_ready, 2'b01);
        step();
        clear         = 1'b0;
        bus.mc_ready  = 1'b0;
        bus.req_valid = '0;
        chk("clr_wr.no_abort_after", bus.mc_abort, 1'b0);
        chk("clr_wr.state", dbg_state, 1'b0);

        // rdy_in low: no grant in IDLE, frozen completion in BUSY
        set_ch(1, 1'b0, 3'd2, 32'h0000_0500, 32'h0);
        bus.req_valid = 2'b10;
        rdy = 1'b0;
        step();
        chk("stall.idle_no_grant", bus.mc_valid, 1'b0);
        rdy = 1'b1;
        step();
        chk("stall.grant", bus.mc_valid, 1'b1);
        bus.mc_ready = 1'b1;
        bus.mc_res   = 32'h0000_ABCD;
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall.req_ready", bus.req_ready, 2'b00);
            step();
            chk("stall.state", dbg_state, 1'b1);
            chk("stall.mc_valid", bus.mc_valid, 1'b1);
        end
        rdy = 1'b1;
        #1;
        chk("stall.release_req_ready", bus.req_ready, 2'b10);
        chk("stall.resp_data", bus.resp_data, 32'h0000_ABCD);
        step();
        bus.mc_ready  = 1'b0;
        bus.req_valid = '0;
        chk("stall.done_state", dbg_state, 1'b0);

        // Reset mid-transfer discards it; grant only on second edge after release
        set_ch(0, 1'b0, 3'd2, 32'h0000_0600, 32'h0);
        bus.req_valid = 2'b01;
        step();
        chk("rst_mid.mc_valid", bus.mc_valid, 1'b1);
        bus.mc_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk("rst_mid.mc_valid_low", bus.mc_valid, 1'b0);
        chk("rst_mid.state", dbg_state, 1'b0);
        chk("rst_mid.req_ready", bus.req_ready, 2'b00);
        chk("rst_mid.mc_addr", bus.mc_addr, 32'h0);
        step();
        step();
        bus.mc_ready = 1'b0;
        rst = 1'b0;
        step();
        chk("rst_mid.first_edge_no_grant", bus.mc_valid, 1'b0);
        step();
        chk("rst_mid.second_edge_grant", bus.mc_valid, 1'b1);
        chk("rst_mid.regrant_addr", bus.mc_addr, 32'h0000_0600);
        bus.mc_ready = 1'b1;
        #1;
        chk("rst_mid.req_ready", bus.req_ready, 2'b01);
        step();
        bus.mc_ready  = 1'b0;
        bus.req_valid = '0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
